seg_scan_drv: RTL and testbench
===============================

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit is lit (minimum 2).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port digits  input  16  four 4-bit codes, digit0 = [3:0] (rightmost) to digit3 = [15:12].
REQ-006 SHALL have port dp_en  input  4  decimal-point request per digit, bit i = digit i.
REQ-007 SHALL have port blank_lead  input  1  leading-zero suppression enable.
REQ-008 SHALL have port flash  input  1  blink request (expired-meter indication).
REQ-009 SHALL have port an  output  4  active-low one-hot digit enable, bit i = digit i.
REQ-010 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp  output  1  active-low decimal point.

Function
REQ-012 SHALL register an, seg and dp; no combinational input-to-output path.
REQ-013 SHALL run refresh counter 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the 2-bit digit index advances 0->1->2->3->0.
REQ-014 SHALL, in the cycle the refresh counter is at terminal count, load an=1111, seg=7F, dp=1 (one-cycle anti-ghost blank).
REQ-015 SHALL otherwise load an with bit[index] low and all other bits high, seg/dp from the indexed digit of the shadow register.
REQ-016 SHALL capture digits, dp_en and blank_lead into a shadow register only when the index wraps 3->0, so a frame never mixes old and new values.
REQ-017 SHALL decode codes 0-9 to standard glyphs ('0'=7'b1000000, '1'=7'b1111001, '8'=7'b0000000), code A to '-' (7'b0111111), and codes B-F to blank (7'h7F).
REQ-018 SHALL, with shadow blank_lead=1, blank digit i (i=3..1) when it and every higher digit are 0; digit0 is never suppressed. dp still follows dp_en on a suppressed digit.
REQ-019 SHALL drive dp low when shadow dp_en[index]=1 and the digit is not blanked per REQ-014/REQ-022.
REQ-020 SHALL ignore input changes mid-frame; the index and refresh counter are never disturbed by input activity.

Reset
REQ-021 SHALL, while rst=1, hold an=1111, seg=7F, dp=1, refresh counter 0, index 0, shadow 0 and blink state 0; the first edge with rst=0 loads an=1110 with the digit0 glyph of the shadow value (all zeros: '0').

Configuration
REQ-022 SHALL, with BLINK_EN defined, run blink counter 0..BLINK_DIV-1 toggling a phase bit at terminal count; while flash=1 and phase=1 an is forced 1111. Counter and phase are held at 0 while flash=0, so each flash assertion starts with a visible half-period.
REQ-023 SHALL, with BLINK_EN undefined, omit the blink counter and phase bit and ignore flash.

Structure
REQ-024 SHALL place segment glyph constants (SEG_BLANK, SEG_DASH, digit glyphs) and the 4-bit code-to-glyph function in package seg_pkg.
REQ-025 SHALL instantiate one combinational sub-module seg7_decode (4-bit code in, 7-bit active-low glyph out) using seg_pkg.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-026 SHALL check reset: digits=16'h1234, rst released -> an=1110 seg=7'b1000000 (shadow 0) for 3 cycles, an=1111 for 1 cycle; from the next frame, digit0 shows '4', digit3 shows '1'.
REQ-027 SHALL check scan order: an sequence 1110,1111,1101,1111,1011,1111,0111,1111, period 16 cycles, with seg correct for each digit.
REQ-028 SHALL check suppression: digits=16'h0050, blank_lead=1 -> digit3 and digit2 seg=7F, digit1 '5', digit0 '0'; with blank_lead=0 all four are lit.
REQ-029 SHALL check tearing: change digits from 16'h1111 to 16'h2222 while digit1 is lit -> digit2 and digit3 still show '1' that frame; all show '2' from the next frame.
REQ-030 SHALL check blink (BLINK_EN defined): flash=1 -> 16 cycles normal scan then 16 cycles an=1111, repeating; flash=0 mid-dark -> an resumes scanning next cycle.
REQ-031 SHALL check codes: digits=16'hFBA9, dp_en=0001 -> digit3 and digit2 blank, digit1 '-', digit0 '9' with dp=0 only on digit0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph constants and the 4-bit code to active-low 7-segment glyph mapping.
// Glyph bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Frame-stable copy of the display inputs.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp_en;
    logic        blank_lead;
  } shadow_t;

  function automatic logic [6:0] code_to_glyph(input logic [3:0] code);
    logic [6:0] glyph;
    case (code)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA:    glyph = SEG_DASH;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low 7-segment glyph decoder.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  assign glyph = code_to_glyph(code);

endmodule

// File: rtl/seg_scan_drv.sv
// Four-digit multiplexed 7-segment scanner with frame-atomic input capture,
// leading-zero suppression and an anti-ghost blank slot. Define BLINK_EN to enable flash blinking.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        blank_lead,
  input  logic        flash,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned RefW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);

  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]      idx_q, idx_d;
  shadow_t         shadow_q, shadow_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            ref_tc;
  logic [3:0]      cur_code;
  logic [6:0]      cur_glyph;
  logic [3:0]      suppress;
  logic            lead_zero;
  logic            blink_dark;

  assign ref_tc   = (ref_cnt_q == RefLast);
  assign cur_code = shadow_q.digits[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  // A digit is suppressed only while it and everything to its left are zero.
  always_comb begin
    suppress  = '0;
    lead_zero = shadow_q.blank_lead;
    for (int i = 3; i >= 1; i--) begin
      lead_zero   = lead_zero & (shadow_q.digits[i*4 +: 4] == 4'd0);
      suppress[i] = lead_zero;
    end
  end

`ifdef BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;

  // Held at zero while flash is low so every flash request opens with a lit half-period.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (flash) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
        phase_d     = phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_dark = flash & phase_q;
`else
  logic unused_flash;
  assign unused_flash = flash;
  assign blink_dark   = 1'b0;
`endif

  always_comb begin
    ref_cnt_d = ref_tc ? '0 : ref_cnt_q + RefW'(1);
    idx_d     = ref_tc ? idx_q + 2'd1 : idx_q;
    shadow_d  = shadow_q;
    if (ref_tc && (idx_q == 2'd3)) begin
      shadow_d = '{digits: digits, dp_en: dp_en, blank_lead: blank_lead};
    end
  end

  // The terminal-count slot is always dark so the next digit's anode never sees stale segments.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!ref_tc) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = suppress[idx_q] ? SEG_BLANK : cur_glyph;
      dp_d  = ~shadow_q.dp_en[idx_q];
      if (blink_dark) begin
        an_d = AN_OFF;
        dp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv with REFRESH_DIV=4, BLINK_DIV=16.
// Expected frames are queued from the input values and drained one entry per clock.
module tb_seg_scan_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_en = '0;
  logic        blank_lead = 1'b0;
  logic        flash = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg_scan_drv #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_en      (dp_en),
    .blank_lead (blank_lead),
    .flash      (flash),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       an_only;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0111111;
      default: return 7'h7F;
    endcase
  endfunction

  // One frame = 16 cycles: per digit 3 lit cycles then 1 dark cycle.
  // Cycles with index below dark_n are blink-dark (only an is checked there).
  function automatic void push_frame(input logic [15:0] d, input logic [3:0] dpe,
                                     input logic bl, input int dark_n);
    logic [3:0] sup;
    logic       zrun;
    exp_t       e;
    sup  = '0;
    zrun = bl;
    for (int i = 3; i >= 1; i--) begin
      zrun   = zrun && (d[4*i +: 4] == 4'h0);
      sup[i] = zrun;
    end
    for (int j = 0; j < 16; j++) begin
      int k;
      k = j / 4;
      if ((j % 4) == 3) begin
        e = '{an_only: 1'b0, an: 4'b1111, seg: 7'h7F, dp: 1'b1};
      end else begin
        e.an_only = (j < dark_n);
        e.an      = 4'b1111;
        if (j >= dark_n) e.an[k] = 1'b0;
        e.seg     = sup[k] ? 7'h7F : glyph(d[4*k +: 4]);
        e.dp      = ~dpe[k];
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic apply_reset(input logic [15:0] d, input logic [3:0] dpe, input logic bl);
    @(negedge clk);
    rst        = 1'b1;
    digits     = d;
    dp_en      = dpe;
    blank_lead = bl;
    flash      = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    apply_reset(16'h1234, 4'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1})
      $display("FAIL reset_hold: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
               an, seg, dp);
    else n_pass++;
    rst = 1'b0;
    push_frame(16'h0000, 4'h0, 1'b0, 0);
    push_frame(16'h1234, 4'h0, 1'b0, 0);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (an !== e.an || (!e.an_only && (seg !== e.seg || dp !== e.dp)))
        $display("FAIL reset c=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 c, an, seg, dp, e.an, e.seg, e.dp);
      else n_pass++;
    end
  endtask

  task automatic test_scan_order();
    exp_t e;
    apply_reset(16'h9876, 4'b0101, 1'b1);
    push_frame(16'h0000, 4'h0, 1'b0, 0);
    push_frame(16'h9876, 4'b0101, 1'b1, 0);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (an !== e.an || (!e.an_only && (seg !== e.seg || dp !== e.dp)))
        $display("FAIL scan_order c=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 c, an, seg, dp, e.an, e.seg, e.dp);
      else n_pass++;
    end
  endtask

  task automatic test_suppress();
    exp_t e;
    apply_reset(16'h0050, 4'b1000, 1'b1);
    push_frame(16'h0000, 4'h0, 1'b0, 0);
    push_frame(16'h0050, 4'b1000, 1'b1, 0);
    push_frame(16'h0050, 4'b1000, 1'b0, 0);
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (an !== e.an || (!e.an_only && (seg !== e.seg || dp !== e.dp)))
        $display("FAIL suppress c=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 c, an, seg, dp, e.an, e.seg, e.dp);
      else n_pass++;
      if (c == 21) blank_lead = 1'b0;
    end
  endtask

  task automatic test_tearing();
    exp_t e;
    apply_reset(16'h1111, 4'h0, 1'b0);
    push_frame(16'h0000, 4'h0, 1'b0, 0);
    push_frame(16'h1111, 4'h0, 1'b0, 0);
    push_frame(16'h2222, 4'h0, 1'b0, 0);
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (an !== e.an || (!e.an_only && (seg !== e.seg || dp !== e.dp)))
        $display("FAIL tearing c=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 c, an, seg, dp, e.an, e.seg, e.dp);
      else n_pass++;
      if (c == 21) digits = 16'h2222;  // digit1 is lit here
    end
  endtask

  task automatic test_codes();
    exp_t e;
    apply_reset(16'hFBA9, 4'b0001, 1'b0);
    push_frame(16'h0000, 4'h0, 1'b0, 0);
    push_frame(16'hFBA9, 4'b0001, 1'b0, 0);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (an !== e.an || (!e.an_only && (seg !== e.seg || dp !== e.dp)))
        $display("FAIL codes c=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 c, an, seg, dp, e.an, e.seg, e.dp);
      else n_pass++;
    end
  endtask

`ifdef BLINK_EN
  task automatic test_blink();
    exp_t e;
    apply_reset(16'h1234, 4'h0, 1'b0);
    push_frame(16'h0000, 4'h0, 1'b0, 0);
    push_frame(16'h1234, 4'h0, 1'b0, 0);
    push_frame(16'h1234, 4'h0, 1'b0, 0);
    push_frame(16'h1234, 4'h0, 1'b0, 16);
    push_frame(16'h1234, 4'h0, 1'b0, 0);
    push_frame(16'h1234, 4'h0, 1'b0, 8);
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (an !== e.an || (!e.an_only && (seg !== e.seg || dp !== e.dp)))
        $display("FAIL blink c=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 c, an, seg, dp, e.an, e.seg, e.dp);
      else n_pass++;
      if (c == 32) flash = 1'b1;
      if (c == 88) flash = 1'b0;
    end
  endtask
`else
  task automatic test_flash_ignored();
    exp_t e;
    apply_reset(16'h1234, 4'b0010, 1'b0);
    push_frame(16'h0000, 4'h0, 1'b0, 0);
    push_frame(16'h1234, 4'b0010, 1'b0, 0);
    push_frame(16'h1234, 4'b0010, 1'b0, 0);
    push_frame(16'h1234, 4'b0010, 1'b0, 0);
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (an !== e.an || (!e.an_only && (seg !== e.seg || dp !== e.dp)))
        $display("FAIL flash_ignored c=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 c, an, seg, dp, e.an, e.seg, e.dp);
      else n_pass++;
      if (c == 16) flash = 1'b1;
    end
    flash = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scan_order();
    test_suppress();
    test_tearing();
    test_codes();
`ifdef BLINK_EN
    test_blink();
`else
    test_flash_ignored();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
